// File: rtl/uart_tx_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_ctrl_pkg
// Shared definitions for the UART transmitter:
//   - frame-sequencer state encoding (3-bit)
//   - serial line levels (idle, start, stop)
//   - parity type constants, shared with the external parity calculator
//   - small helpers for parity and counter sizing
// -----------------------------------------------------------------------------
package uart_tx_frame_ctrl_pkg;

  // Frame sequencer states. The values are fixed so the encoding stays stable
  // across the transmitter files.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Serial line levels
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  // Parity type selection used by the parity calculator
  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  // Parity bit from the XOR-reduction of a word and the parity type.
  // Even parity: the bit makes the total number of ones even.
  function automatic logic parity_bit(input logic data_xor, input logic par_type);
    return data_xor ^ par_type;
  endfunction

  // Bit-counter width for a WIDTH-bit word, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 32'd1) ? $clog2(width) : 32'd1;
  endfunction

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_ctrl_if
// Signal bundle between the upstream register/FIFO logic, the external parity
// calculator and the frame controller.
//   P_DATA     : parallel data word (upstream -> controller, parity calc)
//   DATA_VALID : single-cycle transmit request (upstream -> controller)
//   PAR_EN     : parity enable for the requested frame (upstream -> controller)
//   PAR_BIT    : registered parity (parity calc -> controller)
//   PAR_FLAG   : parity compute request (controller -> parity calc)
//   TX_OUT     : serial line (controller -> pad)
//   BUSY       : frame in progress (controller -> upstream)
// Modports: master (upstream side), slave (frame controller), parity (calc).
// -----------------------------------------------------------------------------
interface uart_tx_frame_ctrl_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] P_DATA;
  logic             DATA_VALID;
  logic             PAR_EN;
  logic             PAR_BIT;
  logic             PAR_FLAG;
  logic             TX_OUT;
  logic             BUSY;

  modport master (
    output P_DATA,
    output DATA_VALID,
    output PAR_EN,
    input  PAR_FLAG,
    input  TX_OUT,
    input  BUSY
  );

  modport slave (
    input  P_DATA,
    input  DATA_VALID,
    input  PAR_EN,
    input  PAR_BIT,
    output PAR_FLAG,
    output TX_OUT,
    output BUSY
  );

  modport parity (
    input  P_DATA,
    input  DATA_VALID,
    input  PAR_FLAG,
    output PAR_BIT
  );

endinterface

// File: rtl/uart_tx_frame_ctrl_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_ctrl_serializer
// Shift register plus bit counter for the data phase of a frame.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : capture load_data and clear the counter
//   shift_en   : shift right one bit (LSB leaves first) and count
//   load_data  : parallel word to serialize
//   bit_out    : current data bit (shift register LSB)
//   done       : counter is on the last bit of the word
// WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module uart_tx_frame_ctrl_serializer
  import uart_tx_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             bit_out,
  output logic             done
);

  localparam int CNT_W = int'(cnt_width(WIDTH));

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_s;

  assign done_s  = (cnt_q == CNT_W'(WIDTH - 1));
  assign done    = done_s;
  assign bit_out = shift_q[0];

  // Next shift-register and counter values
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load) begin
      shift_d = load_data;
      cnt_d   = {CNT_W{1'b0}};
    end else if (shift_en) begin
      shift_d = {1'b0, shift_q[WIDTH-1:1]};
      // Saturate on the last bit so the counter never leaves 0..WIDTH-1
      if (!done_s) begin
        cnt_d = cnt_q + CNT_W'(1'b1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end
  end

  // Shift-register and counter flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_ctrl
// UART transmit framing controller. Accepts a parallel word and sends
// start bit, WIDTH data bits (LSB first), optional parity bit and stop bit,
// one bit per CLK cycle.
//   CLK : transmitter clock, one cycle per serial bit
//   RST : asynchronous active-low reset
//   bus : uart_tx_frame_ctrl_if.slave
//         in  P_DATA, DATA_VALID, PAR_EN, PAR_BIT
//         out PAR_FLAG, TX_OUT, BUSY
// A request is taken only in IDLE; requests during a frame are ignored.
// -----------------------------------------------------------------------------
module uart_tx_frame_ctrl
  import uart_tx_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_tx_frame_ctrl_if.slave   bus
);

  tx_state_e state_q, state_d;
  logic      par_en_q, par_en_d;

  logic      load_s;
  logic      shift_en_s;
  logic      ser_bit_s;
  logic      ser_done_s;
  logic      tx_s;
  logic      busy_s;
  logic      par_flag_s;

  uart_tx_frame_ctrl_serializer #(
    .WIDTH (WIDTH)
  ) u_serializer (
    .clk       (CLK),
    .rst_n     (RST),
    .load      (load_s),
    .shift_en  (shift_en_s),
    .load_data (bus.P_DATA),
    .bit_out   (ser_bit_s),
    .done      (ser_done_s)
  );

  // State and captured parity-enable flops
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      par_en_q <= par_en_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.DATA_VALID) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: state_d = ST_DATA;
      ST_DATA: begin
        if (ser_done_s) begin
          if (par_en_q) begin
            state_d = ST_PARITY;
          end else begin
            state_d = ST_STOP;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Parity enable is frozen at acceptance for the whole frame
  always_comb begin
    par_en_d = par_en_q;
    if (load_s) begin
      par_en_d = bus.PAR_EN;
    end else begin
      par_en_d = par_en_q;
    end
  end

  // Output decode of the registered state
  always_comb begin
    tx_s       = IDLE_LEVEL;
    busy_s     = 1'b1;
    par_flag_s = 1'b0;
    load_s     = 1'b0;
    shift_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_s = 1'b0;
        load_s = bus.DATA_VALID;
      end
      ST_START: tx_s = START_BIT;
      ST_DATA: begin
        tx_s       = ser_bit_s;
        shift_en_s = 1'b1;
        // Parity calculator registers PAR_BIT on the edge ending the last
        // data bit, so it is stable throughout the parity slot.
        par_flag_s = ser_done_s & par_en_q;
      end
      ST_PARITY: tx_s = bus.PAR_BIT;
      ST_STOP:   tx_s = STOP_BIT;
      default: begin
        tx_s   = IDLE_LEVEL;
        busy_s = 1'b0;
      end
    endcase
  end

  assign bus.TX_OUT   = tx_s;
  assign bus.BUSY     = busy_s;
  assign bus.PAR_FLAG = par_flag_s;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame_ctrl
// Directed and randomized frames checked against a frame-level reference:
// the expected line sequence is built as a list of bits from the word,
// parity enable and parity type. A behavioural parity calculator supplies
// PAR_BIT.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame_ctrl;
  import uart_tx_frame_ctrl_pkg::*;

  localparam int W = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic par_odd = 1'b0;
  logic [W-1:0] pc_word;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_frame_ctrl_if #(.WIDTH(W)) bus ();

  uart_tx_frame_ctrl #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Behavioural parity calculator: latches the word on any request outside
  // PAR_FLAG, registers parity when PAR_FLAG is high.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_word     <= '0;
      bus.PAR_BIT <= 1'b0;
    end else begin
      if (bus.DATA_VALID && !bus.PAR_FLAG) pc_word <= bus.P_DATA;
      if (bus.PAR_FLAG) bus.PAR_BIT <= (^pc_word) ^ par_odd;
    end
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"}, bus.TX_OUT, 1'b1);
    check({tag, "_busy"}, bus.BUSY, 1'b0);
    check({tag, "_flag"}, bus.PAR_FLAG, 1'b0);
  endtask

  // Sends one frame and checks every line bit. inject_at: frame index at
  // which a stray 8'hFF request is pulsed. rst_at: frame index at which
  // reset is asserted (task returns with RST low). -1 disables either.
  task automatic run_frame(input logic [W-1:0] data, input logic pen,
                           input logic odd, input int inject_at,
                           input int rst_at);
    logic exp_bits[$];
    int   flag_idx;
    exp_bits = {};
    exp_bits.push_back(1'b0);
    for (int i = 0; i < W; i++) exp_bits.push_back(data[i]);
    if (pen) exp_bits.push_back((($countones(data) % 2) == 1) ^ odd);
    exp_bits.push_back(1'b1);
    flag_idx = pen ? W : -1;

    check("req_while_idle", bus.BUSY, 1'b0);
    par_odd        = odd;
    bus.P_DATA     = data;
    bus.PAR_EN     = pen;
    bus.DATA_VALID = 1'b1;
    tick();
    bus.DATA_VALID = 1'b0;
    for (int i = 0; i < exp_bits.size(); i++) begin
      if (i > 0) tick();
      if (i == rst_at) begin
        RST = 1'b0;
        #1;
        check_idle("async_rst");
        return;
      end
      check($sformatf("tx_%02h_bit%0d", data, i), bus.TX_OUT, exp_bits[i]);
      check($sformatf("busy_%02h_bit%0d", data, i), bus.BUSY, 1'b1);
      check($sformatf("flag_%02h_bit%0d", data, i), bus.PAR_FLAG, i == flag_idx);
      if (i == inject_at) begin
        bus.P_DATA     = 8'hFF;
        bus.DATA_VALID = 1'b1;
      end else begin
        // Mid-frame input changes must not disturb the frame
        bus.DATA_VALID = 1'b0;
        bus.P_DATA     = W'($urandom);
        bus.PAR_EN     = 1'($urandom);
      end
    end
    bus.DATA_VALID = 1'b0;
    tick();
    check_idle($sformatf("end_%02h", data));
  endtask

  initial begin
    logic [W-1:0] rdata;
    logic         rpen;
    logic         rodd;
    int           gap;

    bus.P_DATA     = '0;
    bus.DATA_VALID = 1'b0;
    bus.PAR_EN     = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    check_idle("reset");
    tick();
    tick();
    RST = 1'b1;
    tick();
    check_idle("post_reset");

    // Parity frame, even parity
    run_frame(8'hA5, 1'b1, EVEN, -1, -1);
    // No parity
    run_frame(8'h3C, 1'b0, EVEN, -1, -1);
    tick();

    // Request during DATA must be ignored, no second frame
    run_frame(8'h01, 1'b0, EVEN, 4, -1);
    for (int i = 0; i < 12; i++) begin
      tick();
      check_idle("no_second_frame");
    end

    // Back-to-back, odd parity, second request in first idle cycle
    run_frame(8'h55, 1'b1, ODD, -1, -1);
    run_frame(8'hAA, 1'b1, ODD, -1, -1);
    tick();

    // Reset during data bit 3, then a clean frame
    run_frame(8'hF0, 1'b1, EVEN, -1, 4);
    tick();
    check_idle("held_rst");
    RST = 1'b1;
    tick();
    check_idle("after_rst");
    run_frame(8'h0F, 1'b1, EVEN, -1, -1);

    // Randomized frames with random idle gaps
    for (int n = 0; n < 24; n++) begin
      rdata = W'($urandom);
      rpen  = 1'($urandom);
      rodd  = 1'($urandom);
      run_frame(rdata, rpen, rodd, -1, -1);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        check_idle("gap");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
- Framing controller and serializer for the UART transmitter.
- Accepts a parallel byte from the upstream register/FIFO interface and sequences start, data, optional parity and stop bits onto the serial line.
- Drives PAR_FLAG into the transmitter's parity calculator and consumes its registered PAR_BIT in the parity slot.
- Runs on the UART TX clock (one bit period per clock).

Parameters:
- WIDTH, 8, data word width in bits; sets shift-register size and bit-counter range.

Ports:
- CLK  input  1  transmitter clock, one cycle per serial bit.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  WIDTH  parallel data word; sampled only on acceptance.
- DATA_VALID  input  1  single-cycle request to transmit P_DATA.
- PAR_EN  input  1  parity enable; sampled on acceptance, held for the whole frame.
- PAR_BIT  input  1  registered parity from the parity calculator; valid one cycle after PAR_FLAG.
- PAR_FLAG  output  1  request to the parity calculator to compute parity from its latched word.
- TX_OUT  output  1  serial line; idle level 1.
- BUSY  output  1  high while a frame is in progress.

Behaviour:
- Clock and reset: one clock CLK; reset RST is asynchronous and active-low.
- Reset values: state=IDLE, shift register=0, bit counter=0, par_en_q=0. Resulting outputs: TX_OUT=1, BUSY=0, PAR_FLAG=0.
- States: IDLE, START, DATA, PARITY, STOP. State, shift register, counter and par_en_q are all registered.
- TX_OUT is a decode of registered state: IDLE=1, START=0, DATA=shift[0], PARITY=PAR_BIT, STOP=1.
- IDLE: when DATA_VALID=1 at edge k:
  - load shift<=P_DATA, par_en_q<=PAR_EN, cnt<=0;
  - go to START. TX_OUT=0 in cycle k+1.
- START -> DATA after one cycle.
- DATA:
  - one cycle per bit, LSB first; shift right each cycle, cnt++.
  - At cnt==WIDTH-1: go to PARITY if par_en_q, else STOP.
  - Data bits occupy cycles k+2 .. k+WIDTH+1.
- PAR_FLAG is a combinational decode: 1 only when state==DATA && cnt==WIDTH-1 && par_en_q. The parity calculator registers PAR_BIT on that edge, so it is valid throughout PARITY.
- PARITY: one cycle (k+WIDTH+2), then STOP.
- STOP: one cycle (k+WIDTH+3 with parity, k+WIDTH+2 without), then IDLE.
- BUSY = (state != IDLE). It is high from k+1 through the stop cycle inclusive.
- Frame length is WIDTH+3 cycles with parity and WIDTH+2 without.
- DATA_VALID while BUSY=1: ignored; no reload, no state change.
- System contract: upstream pulses DATA_VALID only when BUSY=0, because the parity calculator latches any DATA_VALID while PAR_FLAG=0. The bench asserts this contract.
- Back-to-back frames: DATA_VALID in the first IDLE cycle after STOP is accepted; the minimum inter-frame gap is one idle cycle.
- PAR_EN and P_DATA changes mid-frame have no effect on the current frame.
- Reset mid-frame: immediate return to IDLE, TX_OUT=1, BUSY=0. The partial frame is dropped and the next DATA_VALID starts a fresh frame.
- Width rules:
  - cnt width = $clog2(WIDTH), minimum 1.
  - The cnt compare uses WIDTH-1 sized to the counter width.
  - No arithmetic overflow is possible: cnt never exceeds WIDTH-1.

Decomposition:
- Shared UART package:
  - state encoding localparams (IDLE/START/DATA/PARITY/STOP, 3-bit);
  - line-level constants IDLE_LEVEL=1, START_BIT=0, STOP_BIT=1;
  - parity type constants EVEN=0, ODD=1, shared with the parity calculator.
- One natural sub-module: uart_tx_serializer (shift register + bit counter + done flag), driven by the FSM's load and enable.
- The parity calculator stays external and is connected at the UART_TX top level.

Test Plan:
- Reset behaviour: assert RST low mid-simulation -> TX_OUT=1, BUSY=0, PAR_FLAG=0 immediately, with no clock needed.
- Frame with parity: P_DATA=8'hA5, PAR_EN=1, parity calculator set to even -> TX_OUT = 0, 1,0,1,0,0,1,0,1, 0, 1 over 11 cycles. PAR_FLAG is high only in the 8th data cycle, and BUSY falls after the stop cycle.
- Frame without parity: P_DATA=8'h3C, PAR_EN=0 -> TX_OUT = 0, 0,0,1,1,1,1,0,0, 1 over 10 cycles. PAR_FLAG stays 0 throughout.
- Busy masking: DATA_VALID pulse with P_DATA=8'hFF during DATA of an 8'h01 frame -> the frame still serializes 8'h01 and no second frame follows.
- Back-to-back: frames 8'h55 then 8'hAA with odd parity, the second DATA_VALID in the first IDLE cycle -> two complete frames with exactly one idle-high cycle between them and correct parity bits 1 and 1.
- Mid-frame reset: RST low during bit 3 of 8'hF0 -> TX_OUT=1 at once. After release, a new 8'h0F request produces a clean full frame.
